quad_encoder_emitter: RTL
=========================

// Module: quad_encoder_emitter
// PURPOSE
//  Quadrature transmitter: produces enc_a/enc_b waveforms equivalent to a
//  mechanical rotary encoder turned a commanded number of detent edges.
//  It is the driving end of the encoder interface that rgb_mixer decodes.
//  Used on-chip as a loop-back stimulus source and exported to pins for
//  bench characterisation of the encoder/debounce path.
// PARAMETERS
//  CNT_W  8   width of step count per command (max 2^CNT_W-1 edges)
//  DIV_W  16  width of period field (clocks per quadrature edge)
//  POS_W  8   width of running position counter (two's complement, wraps)
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      high while IDLE; command accepted when valid&ready
//  cmd_dir    in   1      1 = CW (position increments), 0 = CCW
//  cmd_steps  in   CNT_W  number of quadrature edges to emit
//  period     in   DIV_W  clocks between edges; 0 treated as 1
//  abort      in   1      stop current command after current cycle
//  enc_a      out  1      quadrature channel A (registered)
//  enc_b      out  1      quadrature channel B (registered)
//  busy       out  1      high in RUN
//  done       out  1      one-cycle pulse on completion or abort
//  position   out  POS_W  signed net edge count since reset
// BEHAVIOUR
//  - Reset: enc_a=0, enc_b=0, busy=0, done=0, cmd_ready=1, position=0,
//    phase=00, FSM=IDLE. Reset mid-command discards it; no done pulse.
//  - FSM: IDLE -> RUN on accept (cmd_steps!=0); IDLE -> DONE on accept
//    with cmd_steps==0; RUN -> DONE when remaining hits 0 or abort;
//    DONE -> IDLE unconditionally (done=1 exactly in the DONE cycle).
//  - Accept latches cmd_dir, cmd_steps, max(period,1); inputs may change after.
//  - Timing: divider loads period-1 at accept; first edge appears on enc_a/b
//    exactly `period` cycles after the accept edge; subsequent edges every
//    `period` cycles. Last edge and entry to DONE occur in the same cycle.
//  - Phase sequence (a,b) CW: 00->10->11->01->00 (A leads B).
//    CCW is the reverse. Exactly one of a/b toggles per edge.
//  - position +1 per CW edge, -1 per CCW edge, wraps modulo 2^POS_W.
//  - Phase is persistent across commands (never reset to 00 except by reset),
//    so back-to-back commands stay glitch-free and Gray-coded.
//  - Direction reversal between commands: first edge of new command steps
//    back along the sequence from the current phase.
//  - abort: ignored in IDLE/DONE. In RUN it has priority over a coincident
//    edge: no edge that cycle, FSM -> DONE, phase and position hold.
//  - cmd_valid during RUN/DONE: not accepted (cmd_ready=0), held by source.
//  - Min period=1 yields an edge every clock; busy deasserts the cycle of DONE.
// STRUCTURE
//  - Package rgb_mixer_pkg: emitter FSM state enum (IDLE/RUN/DONE),
//    2-bit phase typedef, CW next-phase lookup constant shared with decoder.
//  - One sub-module: step_timer (DIV_W down-counter, load/enable, tick out).
//  - Top holds FSM, remaining-step counter, phase register, position counter.
// TESTING
//  1 reset then idle 20 cycles -> enc_a=enc_b=0, cmd_ready=1, no done.
//  2 dir=1, steps=4, period=3 -> edges at accept+3,6,9,12: (a,b)=10,11,01,00;
//    done at cycle 12; position=4.
//  3 dir=0, steps=2, period=0 -> edges at accept+1,+2 (01,11 from 00);
//    position=-2 (8'hFE).
//  4 steps=0 -> no edge, done pulse 1 cycle after accept, cmd_ready back next.
//  5 steps=10, period=5, abort at accept+12 -> exactly 2 edges, done at +12,
//    position=2; abort coincident with an edge suppresses that edge.
//  6 POS_W=8: 130 CW edges from reset -> position wraps to 8'h82; then
//    looped into rgb_mixer encoder input -> its count advances by same net.

Source files
------------

// File: rtl/quad_encoder_emitter_pkg.sv
// Shared types for the quadrature emitter: FSM states, phase encoding, CW step table.
// Phase is packed as {a, b}; the CW table is the order a decoder expects when A leads B.
package quad_encoder_emitter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} emit_state_t;

  typedef logic [1:0] phase_t;

  // Indexed by current phase: 00->10, 01->00, 10->11, 11->01.
  localparam phase_t CW_NEXT [4] = '{2'b10, 2'b00, 2'b11, 2'b01};

  // CCW is the inverse lookup of the CW table, so both directions share one source.
  function automatic phase_t next_phase(input phase_t p, input logic cw);
    phase_t r;
    r = p;
    if (cw) begin
      r = CW_NEXT[p];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (CW_NEXT[i] == p) r = phase_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_encoder_emitter_if.sv
// Command channel of the quadrature emitter: valid/ready plus direction, step count and period.
// Driven by the master; the emitter takes the slave side.
interface quad_encoder_emitter_if #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] period;

  modport master (output cmd_valid, cmd_dir, cmd_steps, period, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dir, cmd_steps, period, output cmd_ready);
endinterface

// File: rtl/quad_encoder_emitter_step_timer.sv
// Edge-rate divider: loads period-1, counts down while enabled, ticks at zero and reloads.
// A tick is combinational from the count, so a reload value of 0 ticks every enabled cycle.
module step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tick
);
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] reload;

  assign tick = en && (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= load_val;
      reload <= load_val;
    end else if (en) begin
      count  <= tick ? reload : count - DIV_W'(1);
    end
  end
endmodule

// File: rtl/quad_encoder_emitter.sv
// Quadrature transmitter: emits cmd_steps Gray-coded A/B edges, one every `period` clocks.
// Phase survives between commands so consecutive commands continue the sequence glitch-free.
module quad_encoder_emitter
  import quad_encoder_emitter_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16,
  parameter int POS_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  quad_encoder_emitter_if.slave cmd,
  input  logic                 abort,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 busy,
  output logic                 done,
  output logic [POS_W-1:0]     position
);
  emit_state_t      state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             dir_q;
  phase_t           phase;
  logic             accept;
  logic             step;
  logic [DIV_W-1:0] period_m1;

  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  // A period of 0 behaves as 1, i.e. reload value 0.
  assign period_m1 = (cmd.period == '0) ? '0 : cmd.period - DIV_W'(1);

  // Abort gates the timer so a coincident edge is suppressed.
  step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (period_m1),
    .en       ((state == ST_RUN) && !abort),
    .tick     (step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (cmd.cmd_steps == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (abort || (step && remaining == CNT_W'(1))) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      phase     <= 2'b00;
      position  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        remaining <= cmd.cmd_steps;
        dir_q     <= cmd.cmd_dir;
      end else if (step) begin
        remaining <= remaining - CNT_W'(1);
        phase     <= next_phase(phase, dir_q);
        position  <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
      end
    end
  end

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign busy          = (state == ST_RUN);
  assign done          = (state == ST_DONE);
  assign enc_a         = phase[1];
  assign enc_b         = phase[0];
endmodule
